// File: rtl/seq_pkg.sv
// Shared constants for the serial pattern transmitter and its companion detector bench.
package seq_pkg;

  // Controller states; the encoding is shared with the detector bench.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } seq_state_t;

  // Default pattern geometry and input widths.
  localparam int         DEF_PAT_W   = 3;
  localparam logic [2:0] DEF_PATTERN = 3'b101;
  localparam int         DEF_GAP_W   = 4;
  localparam int         DEF_REP_W   = 8;

  // Width of a bit index that can address every bit of a pat_w-bit pattern.
  function automatic int idx_width(input int pat_w);
    return (pat_w > 1) ? $clog2(pat_w) : 1;
  endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Count register: cleared by reset, reloaded on load, otherwise steps down on dec.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeated rep_cnt times
// (0 = until stop) with gap zero bits between repetitions.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               GAP_W   = DEF_GAP_W,
  parameter int               REP_W   = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             stop,
  output logic             out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = idx_width(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  seq_state_t       state;
  seq_state_t       nxt_state;
  logic [GAP_W-1:0] gap_reg;
  logic             stop_flag;
  logic             stop_now;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             idx_zero;
  logic             idx_load;
  logic             idx_dec;

  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_load_val;
  logic             gap_zero;
  logic             gap_load;
  logic             gap_dec;

  logic [REP_W-1:0] rep_left;
  logic             rep_zero;
  logic             rep_load;
  logic             rep_dec;

  logic             cont;
  logic             last_rep;

  // Bit index of the pattern bit currently on the line.
  seq_down_cnt #(.W(IDX_W)) u_idx_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (idx_load),
    .load_val (IDX_TOP),
    .dec      (idx_dec),
    .count    (idx),
    .zero     (idx_zero)
  );

  // Holds the captured gap length outside GAP and counts the idle bits inside it.
  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  // Repetitions still to send, including the one in progress; zero means continuous.
  seq_down_cnt #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load),
    .load_val (rep_cnt),
    .dec      (rep_dec),
    .count    (rep_left),
    .zero     (rep_zero)
  );

  // A zero repetition count is never decremented, so it doubles as the continuous-mode flag.
  assign cont     = rep_zero;
  assign last_rep = !rep_zero && (rep_left == REP_W'(1));
  assign stop_now = stop_flag | stop;

  // Next-state and counter-control decisions from the registered state and counters.
  always_comb begin
    nxt_state    = state;
    idx_load     = 1'b0;
    idx_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    gap_load_val = gap_reg;
    rep_load     = 1'b0;
    rep_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state    = SEND;
          idx_load     = 1'b1;
          gap_load     = 1'b1;
          gap_load_val = gap;
          rep_load     = 1'b1;
        end
      end
      SEND: begin
        if (!idx_zero) begin
          idx_dec = 1'b1;
        end else if (last_rep || stop_now) begin
          nxt_state = DONE;
        end else begin
          idx_load  = 1'b1;
          rep_dec   = !cont;
          nxt_state = gap_zero ? SEND : GAP;
        end
      end
      GAP: begin
        if (stop_now) begin
          nxt_state = DONE;
        end else if (gap_cnt == GAP_W'(1)) begin
          nxt_state = SEND;
          gap_load  = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // Bit index that will be current after the next edge, used to register the data bit.
  always_comb begin
    nxt_idx = idx;
    if (idx_load) begin
      nxt_idx = IDX_TOP;
    end else if (idx_dec) begin
      nxt_idx = idx - IDX_W'(1);
    end
  end

  // State register, captured gap length, sticky stop request and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      gap_reg   <= '0;
      stop_flag <= 1'b0;
      out       <= 1'b0;
      frame     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && start) begin
        gap_reg <= gap;
      end
      if (state == IDLE) begin
        stop_flag <= 1'b0;
      end else if (stop) begin
        stop_flag <= 1'b1;
      end
      out   <= (nxt_state == SEND) && PATTERN[nxt_idx];
      frame <= (nxt_state == SEND);
      busy  <= (nxt_state != IDLE);
      done  <= (nxt_state == DONE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: a sequence-level model fills a scoreboard
// queue per transfer, and a monitor compares every busy cycle against it.
module tb_seq_pattern_gen;

  localparam int PAT_W     = 3;
  localparam int GAP_W     = 4;
  localparam int REP_W     = 8;
  localparam int MAX_CYC   = 4000;

  logic             clk;
  logic             reset;
  logic             start;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap;
  logic             stop;
  logic             out;
  logic             frame;
  logic             busy;
  logic             done;

  logic [PAT_W-1:0] pat = 3'b101;
  logic [2:0]       sb[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  bit               mon_en   = 1'b0;

  seq_pattern_gen dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rep_cnt (rep_cnt),
    .gap     (gap),
    .stop    (stop),
    .out     (out),
    .frame   (frame),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: expected {out,frame,done} for every busy cycle of one transfer.
  // stop_at = busy cycle (1-based) whose closing edge samples stop, 0 = never.
  // reset_at = busy cycle whose closing edge applies reset, 0 = never.
  function automatic int modelPush(input int rep, input int g, input int stop_at, input int reset_at);
    int  cyc     = 0;
    int  r       = 0;
    bit  stopped = 1'b0;
    forever begin
      r++;
      for (int b = PAT_W - 1; b >= 0; b--) begin
        cyc++;
        if (reset_at == 0 || cyc <= reset_at) sb.push_back({pat[b], 1'b1, 1'b0});
      end
      if ((rep != 0 && r == rep) || (stop_at != 0 && stop_at <= cyc) || cyc > MAX_CYC) break;
      for (int k = 0; k < g; k++) begin
        cyc++;
        if (reset_at == 0 || cyc <= reset_at) sb.push_back(3'b000);
        if (stop_at != 0 && stop_at <= cyc) begin
          stopped = 1'b1;
          break;
        end
      end
      if (stopped) break;
    end
    cyc++;
    if (reset_at == 0 || cyc <= reset_at) sb.push_back(3'b001);
    return cyc;
  endfunction

  // Monitor: pops one expectation per busy cycle; idle cycles must be quiet.
  initial begin
    logic [2:0] e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_busy", 32'(busy), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_frame_done", 32'({out, frame, done}), 32'(e));
        end
      end else begin
        checkOutput("idle_quiet", 32'({busy, out, frame, done}), 32'd0);
      end
    end
  end

  // One transfer with optional stop, reset, and stop asserted together with start.
  task automatic applyStimulus(input int rep, input int g, input int stop_at, input int reset_at,
                               input bit stop_with_start);
    int c;
    void'(modelPush(rep, g, stop_at, reset_at));
    rep_cnt = REP_W'(rep);
    gap     = GAP_W'(g);
    start   = 1'b1;
    stop    = stop_with_start;
    @(posedge clk); #1;
    start   = 1'b0;
    stop    = 1'b0;
    rep_cnt = REP_W'($urandom);
    gap     = GAP_W'($urandom);
    c = 1;
    forever begin
      stop  = (c == stop_at);
      reset = !(c == reset_at);
      if (c == 1) begin
        @(negedge clk);
        checkOutput("latency_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      stop  = 1'b0;
      reset = 1'b1;
      if (c == reset_at) begin
        sb.delete();
        @(negedge clk);
        checkOutput("after_reset", 32'({out, frame, busy, done}), 32'd0);
        @(posedge clk); #1;
        break;
      end
      if (!busy) break;
      c++;
      if (c > MAX_CYC) begin
        checkOutput("transfer_timeout", 32'(c), 32'(MAX_CYC));
        break;
      end
    end
    checkOutput("queue_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // start held high across a transfer: the next one begins one idle cycle after done,
  // and extra start pulses during the second transfer add no bits.
  task automatic applyHeldStart(input int rep, input int g);
    int len;
    int c;
    len = modelPush(rep, g, 0, 0);
    void'(modelPush(rep, g, 0, 0));
    rep_cnt = REP_W'(rep);
    gap     = GAP_W'(g);
    start   = 1'b1;
    @(posedge clk); #1;
    repeat (len) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("held_start_idle_gap", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("held_start_restart", 32'(busy), 32'd1);
    c = 0;
    forever begin
      @(posedge clk); #1;
      if (!busy) break;
      start = 1'($urandom_range(0, 1));
      c++;
      if (c > MAX_CYC) begin
        checkOutput("held_start_timeout", 32'(c), 32'(MAX_CYC));
        break;
      end
    end
    start = 1'b0;
    checkOutput("held_queue_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Main sequence: reset check, directed scenarios, then randomized transfers.
  initial begin
    int rep;
    int g;
    int sa;
    reset   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    rep_cnt = '0;
    gap     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 32'({out, frame, busy, done}), 32'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed: single repetition, no gap");
    applyStimulus(1, 0, 0, 0, 1'b0);
    $display("[TB] directed: two repetitions, gap 2");
    applyStimulus(2, 2, 0, 0, 1'b0);
    $display("[TB] directed: three repetitions back-to-back");
    applyStimulus(3, 0, 0, 0, 1'b0);
    $display("[TB] directed: continuous, gap 1, stop in rep 4 bit 2");
    applyStimulus(0, 1, 14, 0, 1'b0);
    $display("[TB] directed: reset during second pattern bit");
    applyStimulus(2, 1, 0, 2, 1'b0);
    applyStimulus(1, 0, 0, 0, 1'b0);
    $display("[TB] directed: start and stop together in IDLE");
    applyStimulus(2, 1, 0, 0, 1'b1);
    $display("[TB] directed: stop during a gap");
    applyStimulus(0, 3, 5, 0, 1'b0);
    $display("[TB] directed: maximum gap");
    applyStimulus(2, 15, 0, 0, 1'b0);
    $display("[TB] directed: start held high");
    applyHeldStart(2, 1);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 25; t++) begin
      rep = $urandom_range(0, 4);
      g   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      sa  = (rep == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      applyStimulus(rep, g, sa, 0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
